// File: rtl/unsigned_product_accumulator.sv
// Accumulates a run of Length_In unsigned products into a saturating sum.
// Handshakes products in with valid/ready and hands the result out with valid/ready.
module unsigned_product_accumulator #(
    parameter int PRODUCT_WIDTH = 4,
    parameter int SUM_WIDTH     = 8,
    parameter int COUNT_WIDTH   = 4
) (
    input  logic                     Clock_In,
    input  logic                     Reset_In,
    input  logic                     Enable_In,
    input  logic                     Start_In,
    input  logic [COUNT_WIDTH-1:0]   Length_In,
    input  logic [PRODUCT_WIDTH-1:0] Product_In,
    input  logic                     Product_Valid_In,
    output logic                     Product_Ready_Out,
    input  logic                     Result_Ready_In,
    output logic [SUM_WIDTH-1:0]     Sum_Out,
    output logic                     Sum_Valid_Out,
    output logic                     Busy_Out,
    output logic                     Overflow_Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PAD = SUM_WIDTH + 1 - PRODUCT_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] ONE = 1;

    state_t                 state_q, state_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [SUM_WIDTH:0]     sum_ext;
    logic                   accept;

    // Ready depends only on state and enable, never on the incoming valid.
    assign Product_Ready_Out = (state_q == ACCUM) && Enable_In;
    assign Sum_Valid_Out     = (state_q == DONE);
    assign Busy_Out          = (state_q != IDLE);
    assign Overflow_Out      = overflow_q;
    assign Sum_Out           = Enable_In ? sum_q : {SUM_WIDTH{1'bz}};

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        accept     = Product_Ready_Out && Product_Valid_In;
        // One extra bit catches the carry that signals saturation.
        sum_ext    = {1'b0, sum_q} + {{PAD{1'b0}}, Product_In};

        if (Enable_In) begin
            case (state_q)
                IDLE: begin
                    if (Start_In) begin
                        count_d    = Length_In;
                        sum_d      = '0;
                        overflow_d = 1'b0;
                        state_d    = (Length_In == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (sum_ext[SUM_WIDTH]) begin
                            sum_d      = '1;
                            overflow_d = 1'b1;
                        end else begin
                            sum_d = sum_ext[SUM_WIDTH-1:0];
                        end
                        count_d = count_q - ONE;
                        if (count_q == ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (Result_Ready_In) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// Directed bench for unsigned_product_accumulator: an 8-bit-sum instance and a
// 4-bit-sum instance share all inputs so saturation can be exercised alongside.
module tb_unsigned_product_accumulator;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [3:0] len;
    logic [3:0] prod;
    logic       pv;
    logic       rr;

    logic       ready8, sv8, busy8, ovf8;
    logic [7:0] sum8;
    logic       ready4, sv4, busy4, ovf4;
    logic [3:0] sum4;

    int n_vec = 0;
    int n_err = 0;

    unsigned_product_accumulator #(
        .PRODUCT_WIDTH(4), .SUM_WIDTH(8), .COUNT_WIDTH(4)
    ) dut8 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Start_In(start),
        .Length_In(len), .Product_In(prod), .Product_Valid_In(pv),
        .Product_Ready_Out(ready8), .Result_Ready_In(rr), .Sum_Out(sum8),
        .Sum_Valid_Out(sv8), .Busy_Out(busy8), .Overflow_Out(ovf8)
    );

    unsigned_product_accumulator #(
        .PRODUCT_WIDTH(4), .SUM_WIDTH(4), .COUNT_WIDTH(4)
    ) dut4 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Start_In(start),
        .Length_In(len), .Product_In(prod), .Product_Valid_In(pv),
        .Product_Ready_Out(ready4), .Result_Ready_In(rr), .Sum_Out(sum4),
        .Sum_Valid_Out(sv4), .Busy_Out(busy4), .Overflow_Out(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; len = 4'd0;
        prod = 4'd0; pv = 1'b0; rr = 1'b0;

        // Reset state, before any clock edge
        #2;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_valid", 32'(sv8), 32'd0);
        chk("rst_ready", 32'(ready8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic: 9 + 6 + 4
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        chk("basic_busy", 32'(busy8), 32'd1);
        chk("basic_ready", 32'(ready8), 32'd1);
        chk("basic_valid_early", 32'(sv8), 32'd0);
        pv = 1'b1; prod = 4'd9;
        tick();
        chk("basic_sum1", 32'(sum8), 32'd9);
        prod = 4'd6;
        tick();
        chk("basic_sum2", 32'(sum8), 32'd15);
        prod = 4'd4;
        tick();
        pv = 1'b0;
        chk("basic_sum", 32'(sum8), 32'd19);
        chk("basic_valid", 32'(sv8), 32'd1);
        chk("basic_ovf", 32'(ovf8), 32'd0);
        chk("basic_ready_done", 32'(ready8), 32'd0);
        chk("basic_sat4_sum", 32'(sum4), 32'd15);
        chk("basic_sat4_ovf", 32'(ovf4), 32'd1);
        rr = 1'b1;
        tick();
        rr = 1'b0;
        chk("basic_idle_valid", 32'(sv8), 32'd0);
        chk("basic_idle_busy", 32'(busy8), 32'd0);
        chk("basic_idle_sum_held", 32'(sum8), 32'd19);

        // Backpressure and gaps: valid 1,0,0,1 with products 3 then 2
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        pv = 1'b1; prod = 4'd3;
        tick();
        chk("bp_sum1", 32'(sum8), 32'd3);
        pv = 1'b0; prod = 4'd15;
        tick();
        tick();
        chk("bp_gap_sum", 32'(sum8), 32'd3);
        chk("bp_gap_valid", 32'(sv8), 32'd0);
        pv = 1'b1; prod = 4'd2;
        tick();
        pv = 1'b0;
        chk("bp_sum", 32'(sum8), 32'd5);
        chk("bp_valid", 32'(sv8), 32'd1);
        // Start pulses in DONE are ignored
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            len = 4'd7;
            tick();
            chk("bp_hold_valid", 32'(sv8), 32'd1);
            chk("bp_hold_sum", 32'(sum8), 32'd5);
        end
        // Start during the DONE-to-IDLE handshake is ignored
        rr = 1'b1; start = 1'b1; len = 4'd7;
        tick();
        rr = 1'b0; start = 1'b0;
        chk("bp_idle_valid", 32'(sv8), 32'd0);
        chk("bp_idle_busy", 32'(busy8), 32'd0);
        tick();
        chk("hs_start_ignored_busy", 32'(busy8), 32'd0);
        chk("hs_start_ignored_sum", 32'(sum8), 32'd5);

        // Zero length
        start = 1'b1; len = 4'd0; pv = 1'b1; prod = 4'd5;
        tick();
        start = 1'b0;
        chk("zero_valid", 32'(sv8), 32'd1);
        chk("zero_sum", 32'(sum8), 32'd0);
        chk("zero_busy", 32'(busy8), 32'd1);
        chk("zero_ready", 32'(ready8), 32'd0);
        tick();
        pv = 1'b0;
        chk("zero_no_accept", 32'(sum8), 32'd0);
        rr = 1'b1;
        tick();
        rr = 1'b0;

        // Saturation on the 4-bit instance: 9 + 9 + 9
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        pv = 1'b1; prod = 4'd9;
        tick();
        chk("sat_sum1", 32'(sum4), 32'd9);
        chk("sat_ovf1", 32'(ovf4), 32'd0);
        tick();
        chk("sat_sum2", 32'(sum4), 32'd15);
        chk("sat_ovf2", 32'(ovf4), 32'd1);
        tick();
        pv = 1'b0;
        chk("sat_sum", 32'(sum4), 32'd15);
        chk("sat_ovf", 32'(ovf4), 32'd1);
        chk("sat_valid", 32'(sv4), 32'd1);
        chk("sat_wide_sum", 32'(sum8), 32'd27);
        chk("sat_wide_ovf", 32'(ovf8), 32'd0);
        rr = 1'b1;
        tick();
        rr = 1'b0;
        chk("sat_ovf_idle", 32'(ovf4), 32'd1);
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        chk("sat_ovf_cleared", 32'(ovf4), 32'd0);
        chk("sat_sum_cleared", 32'(sum4), 32'd0);

        // Start in ACCUM must not reload the count (run length stays 1)
        start = 1'b1; len = 4'd9;
        tick();
        start = 1'b0;
        chk("accum_start_busy", 32'(busy8), 32'd1);

        // Enable low mid-ACCUM with valid held
        en = 1'b0; pv = 1'b1; prod = 4'd7;
        #1;
        chk("en_ready", 32'(ready8), 32'd0);
        n_vec++;
        assert (sum8 === 8'bzzzzzzzz) else begin
            n_err++;
            $error("FAIL en_sum_z observed=%b expected=zzzzzzzz", sum8);
        end
        tick();
        tick();
        chk("en_busy", 32'(busy8), 32'd1);
        chk("en_no_accept", 32'(sv8), 32'd0);
        en = 1'b1;
        #1;
        chk("en_sum_held", 32'(sum8), 32'd0);
        chk("en_ready_back", 32'(ready8), 32'd1);
        tick();
        pv = 1'b0;
        chk("en_resume_sum", 32'(sum8), 32'd7);
        chk("en_resume_valid", 32'(sv8), 32'd1);
        rr = 1'b1;
        tick();
        rr = 1'b0;

        // Reset pulsed mid-ACCUM, between clock edges
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        pv = 1'b1; prod = 4'd5;
        tick();
        tick();
        pv = 1'b0;
        chk("mid_sum", 32'(sum8), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_sum", 32'(sum8), 32'd0);
        chk("arst_valid", 32'(sv8), 32'd0);
        chk("arst_ready", 32'(ready8), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fresh start after reset
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        pv = 1'b1; prod = 4'd3;
        tick();
        pv = 1'b0;
        chk("fresh_sum", 32'(sum8), 32'd3);
        chk("fresh_valid", 32'(sv8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unsigned_product_accumulator.md
UNSIGNED_PRODUCT_ACCUMULATOR -- requirements
Module: unsigned_product_accumulator

Interface
REQ-001 The block SHALL have these parameters:
- PRODUCT_WIDTH, default 4: width of each incoming product; matches a 2-bit x 2-bit unsigned multiplier.
- SUM_WIDTH, default 8: width of the accumulator.
- COUNT_WIDTH, default 4: width of the product-count field.

REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of Clock_In. Ports:
- Clock_In  input  1  system clock.
- Reset_In  input  1  asynchronous active-high reset.
- Enable_In  input  1  high: block operates and drives Sum_Out; low: block freezes and Sum_Out is high-Z.
- Start_In  input  1  single-cycle request to begin a new accumulation.
- Length_In  input  COUNT_WIDTH  number of products to accumulate; sampled with Start_In.
- Product_In  input  PRODUCT_WIDTH  unsigned product from the upstream multiplier.
- Product_Valid_In  input  1  Product_In is valid.
- Product_Ready_Out  output  1  block can accept Product_In this cycle.
- Result_Ready_In  input  1  downstream accepts the result.
- Sum_Out  output  SUM_WIDTH  accumulated sum.
- Sum_Valid_Out  output  1  Sum_Out holds the final result.
- Busy_Out  output  1  state is not IDLE.
- Overflow_Out  output  1  the accumulation saturated.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-004 While Enable_In=0, all registers SHALL hold their values, Product_Ready_Out SHALL be 0, and Sum_Out SHALL be high-Z. The other outputs SHALL keep reflecting the held state.
REQ-005 IDLE, when Start_In=1 and Enable_In=1:
- Capture Length_In into the remaining-count register.
- Clear the sum and Overflow_Out.
- Go to ACCUM if Length_In is nonzero.
- Go directly to DONE with sum 0 if Length_In=0.
REQ-006 Start_In SHALL be ignored in ACCUM and DONE.
REQ-007 Product_Ready_Out SHALL equal 1 only in ACCUM with Enable_In=1. It SHALL be a combinational function of state and Enable_In only, never of Product_Valid_In.
REQ-008 A product SHALL be accepted only on a clock edge where Product_Valid_In=1 and Product_Ready_Out=1. On acceptance:
- The sum becomes sum + zero-extended Product_In.
- The remaining count decrements by 1.
REQ-009 On acceptance of the final product (remaining count = 1), the FSM SHALL move to DONE in the same edge. Sum_Valid_Out SHALL rise in the following cycle, which gives a latency of one cycle from the last accepted product.
REQ-010 If an addition exceeds 2^SUM_WIDTH-1, the sum SHALL saturate at all-ones and Overflow_Out SHALL set and stay set until the next accepted Start_In.
REQ-011 In DONE, Sum_Valid_Out SHALL be 1, and Sum_Out and Overflow_Out SHALL be stable.
REQ-012 In DONE, when Result_Ready_In=1 and Enable_In=1, the FSM SHALL go to IDLE and Sum_Valid_Out SHALL be 0 in the next cycle.
REQ-013 A Start_In in the same cycle as the DONE-to-IDLE handshake SHALL be ignored. A new start is accepted only from IDLE.
REQ-014 In IDLE, Sum_Out SHALL keep the last result until the next accepted Start_In.
REQ-015 Busy_Out SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-016 Product_In and Product_Valid_In SHALL be ignored outside ACCUM.

Reset
REQ-017 Reset_In=1 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- sum to 0;
- remaining count to 0;
- Overflow_Out=0, Sum_Valid_Out=0, Product_Ready_Out=0, Busy_Out=0.
REQ-018 A reset asserted mid-accumulation SHALL abandon the run. The first accepted Start_In after reset deassertion SHALL behave as a fresh start.
REQ-019 While Reset_In=1 with Enable_In=1, Sum_Out SHALL drive 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic: Length_In=3, products 9, 6, 4 with Product_Valid_In held high -> 3 accepted in 3 cycles; Sum_Out=19, Sum_Valid_Out=1 one cycle after the third acceptance; Overflow_Out=0.
- Backpressure and gaps: Length_In=2; Product_Valid_In toggles 1,0,0,1 with products 3 then 2 -> Sum_Out=5; Sum_Valid_Out is held over 4 cycles of Result_Ready_In=0, then the FSM reaches IDLE one cycle after Result_Ready_In=1.
- Zero length: Length_In=0 with Start_In -> DONE next cycle, Sum_Out=0, no product accepted.
- Saturation, with SUM_WIDTH=4: Length_In=3, products 9, 9, 9 -> Sum_Out=15, Overflow_Out=1. Overflow_Out then clears on the next Start_In.
- Enable and reset: Enable_In=0 mid-ACCUM with Product_Valid_In=1 -> no acceptance and Sum_Out=Z; re-enabling resumes the run. Reset_In pulsed mid-ACCUM -> IDLE, sum 0, Busy_Out=0 without a clock edge.
- Ignored start: Start_In pulsed in ACCUM and in DONE, including during the DONE-to-IDLE handshake -> no effect on the count or the sum.
